wc_cmd_gen: RTL and testbench
=============================

// Module: wc_cmd_gen
// PURPOSE
//  Front end of window/cursor control: conditions raw board buttons into the WC_CMDS pulse bundle
//  and owns the zoom state (win_numCells). Sits directly upstream of the window/cursor tracker.
//  Provides synchronise, debounce, press-edge pulses, optional auto-repeat, mode toggle and
//  zoom limiting. The tracker sees one clean command per cycle.
// PARAMETERS
//  DB_W          20       width of debounce/repeat counters
//  DB_CYCLES     500000   consecutive stable cycles before a button state is accepted (10 ms @ 50 MHz)
//  REPEAT_DELAY  20000000 cycles a direction must be held before the first repeat pulse
//  REPEAT_PERIOD 5000000  cycles between later repeat pulses
//  MIN_CELLS     8        smallest win_numCells (power of 2)
//  MAX_CELLS     128      largest win_numCells (power of 2, <= 128)
//  INIT_CELLS    16       win_numCells after reset (power of 2, MIN..MAX)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  btn_up        in   1   raw button, asynchronous, active-high (same for the next 6 inputs)
//  btn_down      in   1   raw button
//  btn_left      in   1   raw button
//  btn_right     in   1   raw button
//  btn_mode      in   1   raw button; each accepted press toggles move_mode
//  btn_zoom_in   in   1   raw button
//  btn_zoom_out  in   1   raw button
//  run_mode      in   1   1 = simulation running, 0 = edit
//  wc_cmds       out  7   WC_CMDS packed struct {move_up,move_down,move_left,move_right,move_mode,zoom_in,zoom_out}
//  win_numCells  out  8   current window size in cells
// BEHAVIOUR
//  Reset: all wc_cmds fields 0 (move_mode=0), win_numCells=INIT_CELLS, debounced states 0, counters 0.
//  Each button passes through a 2-flop synchroniser. Then a debouncer: when the synchronised value
//  differs from the debounced value, the counter increments. Otherwise the counter clears. The
//  debounced value flips when the count reaches DB_CYCLES, and the counter clears.
//  Press = debounced 0->1 transition. This gives one candidate pulse in the next cycle.
//  The flopped output pulse appears 1 cycle after the debounced edge. Release produces no pulse.
//  Move pulses (move_*, zoom_*) are exactly 1 cycle wide and registered. At most one is high per cycle:
//   - A zoom candidate beats move candidates. Move candidates lost in that cycle are dropped, not queued.
//   - Direction priority: up > down > left > right. Lower-priority candidates are dropped.
//   - zoom_in and zoom_out candidates in the same cycle are both dropped.
//  zoom_in is issued only if win_numCells > MIN_CELLS. zoom_out is issued only if win_numCells < MAX_CELLS.
//  Otherwise the candidate is silently dropped.
//  win_numCells updates on the clock edge that ends the pulse cycle:
//   - zoom_in halves it; zoom_out doubles it.
//   - During the pulse cycle the tracker sees the OLD win_numCells.
//  move_mode is a level. It toggles on an accepted btn_mode press and is registered like the pulses.
//  run_mode=1 suppresses all move and zoom pulses and freezes move_mode. Debouncers and win_numCells
//  keep their state. Presses made while run_mode=1 are discarded and do not replay on exit.
//  Reset asserted mid-press returns all state to the reset values. A button still held at release
//  of reset yields one pulse after DB_CYCLES+3 cycles.
// CONFIGURATION
//  `WC_AUTOREPEAT_EN defined:
//   - Per-direction hold counter. A direction held debounced-high for REPEAT_DELAY cycles after its
//     press pulse generates a repeat candidate, then another every REPEAT_PERIOD cycles until release.
//   - Repeat candidates obey the same priority and suppression rules as press candidates.
//   - Release clears the counter. Zoom and mode buttons never repeat.
//  Not defined: exactly one pulse per press; no hold counters are synthesised.
// TESTING (bench params: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, INIT_CELLS=16)
//  Bounce btn_up 1,0,1 at 1-cycle spacing, then hold high -> exactly one move_up pulse. It appears
//  7 cycles after the final rise (2 sync + 4 debounce + 1 output flop).
//  Hold btn_zoom_in from 16 cells -> pulse with win_numCells=16; next cycle 8. Press again -> no pulse, stays 8.
//  Press btn_zoom_out 5 times from 8 -> pulses at 8,16,32,64 with values 16,32,64,128; 5th press dropped, stays 128.
//  Drive btn_up and btn_zoom_out debounced-high in the same cycle -> only zoom_out pulses; move_up never issued.
//  Set run_mode=1, press btn_left and btn_mode -> no pulses and move_mode unchanged. Set run_mode=0 -> still none.
//  With `WC_AUTOREPEAT_EN, hold btn_right 30 cycles past its press pulse -> repeats at +10,+13,+16,...,+28.
//  Release -> no more pulses. Without the macro, the same stimulus -> only the press pulse.

Source files
------------

// File: rtl/wc_cmd_gen.sv
// Window/cursor command front end: button synchronise, debounce and press-edge detection, plus the zoom state.
// Optional auto-repeat of the four direction buttons when WC_AUTOREPEAT_EN is defined.
module wc_cmd_gen #(
  parameter int DB_W          = 20,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 20000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int MIN_CELLS     = 8,
  parameter int MAX_CELLS     = 128,
  parameter int INIT_CELLS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_mode,
  input  logic       btn_zoom_in,
  input  logic       btn_zoom_out,
  input  logic       run_mode,
  output logic [6:0] wc_cmds,
  output logic [7:0] win_numCells
);

  localparam int NB     = 7;
  localparam int B_UP   = 6;
  localparam int B_DOWN = 5;
  localparam int B_LEFT = 4;
  localparam int B_RGHT = 3;
  localparam int B_MODE = 2;
  localparam int B_ZIN  = 1;
  localparam int B_ZOUT = 0;

  localparam logic [7:0]      MIN_C  = 8'(MIN_CELLS);
  localparam logic [7:0]      MAX_C  = 8'(MAX_CELLS);
  localparam logic [7:0]      INIT_C = 8'(INIT_CELLS);
  localparam logic [DB_W-1:0] DB_END = DB_W'(DB_CYCLES - 1);

  if ((INIT_CELLS < MIN_CELLS) || (INIT_CELLS > MAX_CELLS) || (MAX_CELLS > 128) ||
      (REPEAT_PERIOD > REPEAT_DELAY) || (REPEAT_PERIOD < 1)) begin : g_bad_params
    $error("wc_cmd_gen: inconsistent parameters");
  end

  logic [NB-1:0]   btn_raw_s;
  logic [NB-1:0]   sync1_r;
  logic [NB-1:0]   sync2_r;
  logic [NB-1:0]   db_r;
  logic [NB-1:0]   db_prev_r;
  logic [DB_W-1:0] db_cnt_r [NB];
  logic [NB-1:0]   press_s;
  logic [NB-1:0]   cand_s;
  logic [NB-1:0]   cmd_next_s;
  logic [NB-1:0]   wc_cmds_r;
  logic [7:0]      cells_r;
  logic [7:0]      cells_next_s;

  // Bit order matches the wc_cmds bundle so candidates map one-to-one onto command bits.
  assign btn_raw_s = {btn_up, btn_down, btn_left, btn_right, btn_mode, btn_zoom_in, btn_zoom_out};

  // Two-flop synchroniser and per-button stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= {NB{1'b0}};
      sync2_r   <= {NB{1'b0}};
      db_r      <= {NB{1'b0}};
      db_prev_r <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) db_cnt_r[i] <= {DB_W{1'b0}};
    end else begin
      sync1_r   <= btn_raw_s;
      sync2_r   <= sync1_r;
      db_prev_r <= db_r;
      for (int i = 0; i < NB; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_END) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
          db_r[i]     <= ~db_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign press_s = db_r & ~db_prev_r;

`ifdef WC_AUTOREPEAT_EN
  // Hold counters count cycles since the press candidate; sized for the repeat delay, not DB_W.
  localparam int              RP_W    = $clog2(REPEAT_DELAY + 1);
  localparam logic [RP_W-1:0] RP_END  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_WRAP = RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);

  logic [RP_W-1:0] hold_cnt_r [4];
  logic [3:0]      rep_s;

  // Repeat candidate fires whenever a still-held direction reaches the delay mark.
  always_comb begin
    rep_s = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if (db_r[B_RGHT + j] && (hold_cnt_r[j] == RP_END)) rep_s[j] = 1'b1;
      else rep_s[j] = 1'b0;
    end
  end

  // Press starts the count, the delay mark wraps back by one period, release clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 4; j++) hold_cnt_r[j] <= {RP_W{1'b0}};
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (!db_r[B_RGHT + j])              hold_cnt_r[j] <= {RP_W{1'b0}};
        else if (press_s[B_RGHT + j])       hold_cnt_r[j] <= RP_ONE;
        else if (hold_cnt_r[j] == RP_END)   hold_cnt_r[j] <= RP_WRAP;
        else if (hold_cnt_r[j] != {RP_W{1'b0}}) hold_cnt_r[j] <= hold_cnt_r[j] + RP_ONE;
        else                                hold_cnt_r[j] <= hold_cnt_r[j];
      end
    end
  end

  assign cand_s = press_s | {rep_s, 3'b000};
`else
  assign cand_s = press_s;
`endif

  // Cell count as it stands after the current edge, so limits see back-to-back zooms correctly.
  always_comb begin
    if (wc_cmds_r[B_ZIN])       cells_next_s = cells_r >> 1;
    else if (wc_cmds_r[B_ZOUT]) cells_next_s = cells_r << 1;
    else                        cells_next_s = cells_r;
  end

  // Arbitration: any zoom candidate wins over moves, conflicting zooms cancel, then up > down > left > right.
  always_comb begin
    cmd_next_s         = {NB{1'b0}};
    cmd_next_s[B_MODE] = wc_cmds_r[B_MODE];
    if (run_mode) begin
      cmd_next_s[B_MODE] = wc_cmds_r[B_MODE];
    end else begin
      cmd_next_s[B_MODE] = wc_cmds_r[B_MODE] ^ cand_s[B_MODE];
      if (cand_s[B_ZIN] || cand_s[B_ZOUT]) begin
        cmd_next_s[B_ZIN]  = cand_s[B_ZIN] & ~cand_s[B_ZOUT] & (cells_next_s > MIN_C);
        cmd_next_s[B_ZOUT] = cand_s[B_ZOUT] & ~cand_s[B_ZIN] & (cells_next_s < MAX_C);
      end else if (cand_s[B_UP]) begin
        cmd_next_s[B_UP] = 1'b1;
      end else if (cand_s[B_DOWN]) begin
        cmd_next_s[B_DOWN] = 1'b1;
      end else if (cand_s[B_LEFT]) begin
        cmd_next_s[B_LEFT] = 1'b1;
      end else if (cand_s[B_RGHT]) begin
        cmd_next_s[B_RGHT] = 1'b1;
      end else begin
        cmd_next_s[B_RGHT] = 1'b0;
      end
    end
  end

  // Registered command bundle and zoom state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc_cmds_r <= {NB{1'b0}};
      cells_r   <= INIT_C;
    end else begin
      wc_cmds_r <= cmd_next_s;
      cells_r   <= cells_next_s;
    end
  end

  assign wc_cmds      = wc_cmds_r;
  assign win_numCells = cells_r;

endmodule

// File: tb/tb_wc_cmd_gen.sv
// Scoreboard bench for wc_cmd_gen: a cycle-stamped reference model queues expected command events,
// a negedge monitor pops and compares them; directed phases plus a randomized button storm.
module tb_wc_cmd_gen;

  localparam int DB    = 4;
  localparam int RD    = 10;
  localparam int RP    = 3;
  localparam int MINC  = 8;
  localparam int MAXC  = 128;
  localparam int INITC = 16;
  localparam int UP = 6, DN = 5, LF = 4, RT = 3, MD = 2, ZI = 1, ZO = 0;

`ifdef WC_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] btn = 7'b0;
  logic       run_mode = 1'b0;
  logic [6:0] wc_cmds;
  logic [7:0] win_numCells;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  wc_cmd_gen #(
    .DB_W(20), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .MIN_CELLS(MINC), .MAX_CELLS(MAXC), .INIT_CELLS(INITC)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn[UP]), .btn_down(btn[DN]), .btn_left(btn[LF]), .btn_right(btn[RT]),
    .btn_mode(btn[MD]), .btn_zoom_in(btn[ZI]), .btn_zoom_out(btn[ZO]),
    .run_mode(run_mode), .wc_cmds(wc_cmds), .win_numCells(win_numCells)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] cmd;
    logic [7:0] cells;
  } ev_t;
  ev_t q[$];

  // Reference model state
  bit [5:0]   hist [7];
  bit [6:0]   m_db, pend, m_cmd;
  int         m_cells;
  int         n0 [7];
  bit         held [7];

  // Model: debounced level = raw value seen 2 edges late that disagreed with it for DB straight samples.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int b = 0; b < 7; b++) begin hist[b] = '0; held[b] = 0; n0[b] = 0; end
        m_db = '0; pend = '0; m_cmd = '0; m_cells = INITC;
      end else begin
        bit [6:0] new_cmd;
        bit [6:0] db_new;
        bit [6:0] nxt;
        if (m_cmd[ZI]) m_cells = m_cells / 2;
        else if (m_cmd[ZO]) m_cells = m_cells * 2;
        new_cmd = '0;
        new_cmd[MD] = m_cmd[MD];
        if (!run_mode) begin
          new_cmd[MD] = m_cmd[MD] ^ pend[MD];
          if (pend[ZI] || pend[ZO]) begin
            new_cmd[ZI] = pend[ZI] && !pend[ZO] && (m_cells > MINC);
            new_cmd[ZO] = pend[ZO] && !pend[ZI] && (m_cells < MAXC);
          end else begin
            for (int d = UP; d >= RT; d--)
              if (pend[d] && (new_cmd[6:3] == 4'b0)) new_cmd[d] = 1'b1;
          end
        end
        if (((new_cmd & 7'b1111011) != 7'b0) || (new_cmd[MD] != m_cmd[MD]))
          q.push_back('{cyc: cyc, cmd: new_cmd, cells: 8'(m_cells)});
        m_cmd = new_cmd;

        db_new = m_db;
        nxt = '0;
        for (int b = 0; b < 7; b++) begin
          bit all_diff;
          hist[b] = {hist[b][4:0], btn[b]};
          all_diff = 1;
          for (int k = 2; k <= 5; k++) if (hist[b][k] == m_db[b]) all_diff = 0;
          if (all_diff) db_new[b] = ~m_db[b];
          if (db_new[b] && !m_db[b]) begin held[b] = 1; n0[b] = cyc; end
          if (!db_new[b]) held[b] = 0;
          if (db_new[b] && held[b]) begin
            int k;
            k = cyc - n0[b];
            if (k == 0) nxt[b] = 1;
            else if (AR && (b >= RT) && (k >= RD) && (((k - RD) % RP) == 0)) nxt[b] = 1;
          end
        end
        m_db = db_new;
        pend = nxt;
      end
    end
  end

  // Monitor state
  bit mon_mode;
  int pcnt [7];
  int plast [7];

  // Monitor: every pulse or move_mode change on the DUT pops one expected event.
  initial begin
    for (int b = 0; b < 7; b++) begin pcnt[b] = 0; plast[b] = -1; end
    mon_mode = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_mode = 0;
      end else begin
        while ((q.size() > 0) && (q[0].cyc < cyc)) begin
          ev_t m;
          m = q.pop_front();
          checks++; errors++;
          $display("FAIL missed_event expected cyc=%0d cmds=%b actual none by cyc=%0d", m.cyc, m.cmd, cyc);
        end
        if (((wc_cmds & 7'b1111011) != 7'b0) || (wc_cmds[MD] != mon_mode)) begin
          checks++;
          for (int b = 0; b < 7; b++) if (wc_cmds[b]) begin pcnt[b]++; plast[b] = cyc; end
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d actual cmds=%b cells=%0d required no event", cyc, wc_cmds, win_numCells);
          end else begin
            ev_t e;
            e = q.pop_front();
            if ((e.cyc != cyc) || (e.cmd != wc_cmds) || (e.cells != win_numCells)) begin
              errors++;
              $display("FAIL event cyc=%0d actual cmds=%b cells=%0d required cyc=%0d cmds=%b cells=%0d",
                       cyc, wc_cmds, win_numCells, e.cyc, e.cmd, e.cells);
            end
          end
        end
        mon_mode = wc_cmds[MD];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
  endtask

  task automatic check_idle(input string name);
    tick(14);
    chk({name, "_queue_drained"}, q.size(), 0);
    chk({name, "_cells"}, int'(win_numCells), m_cells);
    chk({name, "_mode"}, int'(wc_cmds[MD]), int'(m_cmd[MD]));
  endtask

  initial begin
    int base [7];
    int n;
    int saved_mode;

    tick(3);
    chk("reset_cmds", int'(wc_cmds), 0);
    chk("reset_cells", int'(win_numCells), INITC);
    rst = 1'b0;
    tick(2);

    // Bounce 1,0,1 then hold: one pulse 7 cycles after the final rise
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    btn[UP] = 1'b1; tick(1);
    btn[UP] = 1'b0; tick(1);
    btn[UP] = 1'b1; n = cyc;
    tick(15);
    btn[UP] = 1'b0;
    check_idle("bounce");
    chk("bounce_up_count", pcnt[UP] - base[UP], 1);
    chk("bounce_up_latency", plast[UP] - n, 7);

    // Zoom in from 16 to 8, then press again at the floor
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    press(ZI, 10);
    check_idle("zin1");
    chk("zin1_cells", int'(win_numCells), 8);
    press(ZI, 10);
    check_idle("zin2");
    chk("zin_count", pcnt[ZI] - base[ZI], 1);
    chk("zin_floor_cells", int'(win_numCells), 8);

    // Zoom out five times: four pulses, saturates at 128
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    for (int i = 0; i < 5; i++) begin
      press(ZO, 10);
      check_idle("zout");
    end
    chk("zout_count", pcnt[ZO] - base[ZO], 4);
    chk("zout_ceiling_cells", int'(win_numCells), 128);

    // Zoom beats a simultaneous move
    press(ZI, 10);
    check_idle("zin_to_64");
    chk("cells_64", int'(win_numCells), 64);
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    btn[UP] = 1'b1; btn[ZO] = 1'b1;
    tick(10);
    btn[UP] = 1'b0; btn[ZO] = 1'b0;
    check_idle("zoom_vs_move");
    chk("zoom_vs_move_zout", pcnt[ZO] - base[ZO], 1);
    chk("zoom_vs_move_up", pcnt[UP] - base[UP], 0);

    // run_mode suppresses and discards presses
    saved_mode = int'(wc_cmds[MD]);
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    run_mode = 1'b1;
    btn[LF] = 1'b1; btn[MD] = 1'b1;
    tick(10);
    btn[LF] = 1'b0; btn[MD] = 1'b0;
    check_idle("run_on");
    run_mode = 1'b0;
    check_idle("run_off");
    chk("run_left_count", pcnt[LF] - base[LF], 0);
    chk("run_mode_frozen", int'(wc_cmds[MD]), saved_mode);

    // Mode toggles on a press in edit mode
    press(MD, 10);
    check_idle("mode_toggle");
    chk("mode_toggled", int'(wc_cmds[MD]), 1 - saved_mode);

    // Hold right long enough for repeats through +28 only
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    n = cyc;
    press(RT, 30);
    check_idle("hold_right");
    chk("hold_right_count", pcnt[RT] - base[RT], AR ? 8 : 1);
    chk("hold_right_last", plast[RT] - n, AR ? 35 : 7);

    // Reset mid-press with the button still held at reset release
    for (int b = 0; b < 7; b++) base[b] = pcnt[b];
    btn[DN] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("midreset_cmds", int'(wc_cmds), 0);
    chk("midreset_cells", int'(win_numCells), INITC);
    rst = 1'b0; n = cyc;
    tick(12);
    btn[DN] = 1'b0;
    check_idle("midreset");
    chk("midreset_down_count", pcnt[DN] - base[DN], 1);
    chk("midreset_down_latency", plast[DN] - n, DB + 3);

    // Randomized button storm against the model
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 99) == 0) run_mode = ~run_mode;
      tick(1);
    end
    btn = 7'b0;
    run_mode = 1'b0;
    check_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
